// File: rtl/taxi_fare_meter_if.sv
// Control inputs and fare/distance outputs of the taxi fare meter.
// master drives the requests and sensors, slave is the meter itself.
interface taxi_fare_meter_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic        wheel_pulse;
    logic        wait_in;
    logic [31:0] money;
    logic [19:0] dist_m;
    logic        busy;

    modport master (
        output start, stop, clear, wheel_pulse, wait_in,
        input  money, dist_m, busy
    );

    modport slave (
        input  start, stop, clear, wheel_pulse, wait_in,
        output money, dist_m, busy
    );
endinterface

// File: rtl/taxi_fare_meter.sv
// Taxi fare meter: flag-fall fare plus distance and waiting-time increments,
// saturating at MONEY_MAX, with an IDLE/RUN/HOLD trip state machine.
module taxi_fare_meter #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BASE_FARE = 100,
    parameter int unsigned BASE_DIST = 3000,
    parameter int unsigned UNIT_DIST = 500,
    parameter int unsigned UNIT_FARE = 10,
    parameter int unsigned WAIT_UNIT = 60,
    parameter int unsigned WAIT_FARE = 5,
    parameter int unsigned MONEY_MAX = 9999
) (
    input logic               clk,
    input logic               rst_n,
    taxi_fare_meter_if.slave  bus
);

    localparam int unsigned MW   = 32;
    localparam int unsigned DW   = 20;
    localparam int unsigned SUMW = 34;
    localparam int unsigned PW   = (CLK_HZ > 1)    ? $clog2(CLK_HZ)    : 1;
    localparam int unsigned UW   = (UNIT_DIST > 1) ? $clog2(UNIT_DIST) : 1;
    localparam int unsigned SW   = (WAIT_UNIT > 1) ? $clog2(WAIT_UNIT) : 1;
    localparam logic [DW-1:0] DIST_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            load_trip;
    logic            clear_trip;

    logic [2:0]      sync_q;
    logic            metre_strobe;

    logic [MW-1:0]   money_q, money_d;
    logic [DW-1:0]   dist_q, dist_d;
    logic [UW-1:0]   unit_q, unit_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   sec_q, sec_d;
    logic            busy_q;
    logic            dist_inc;
    logic            wait_inc;
    logic [SUMW-1:0] money_sum;

    // Two synchroniser flops plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], bus.wheel_pulse};
        end
    end

    assign metre_strobe = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Trip control: stop wins in RUN, start wins over clear in HOLD.
    always_comb begin
        state_d    = state_q;
        load_trip  = 1'b0;
        clear_trip = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    load_trip = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.start) begin
                    state_d   = RUN;
                    load_trip = 1'b1;
                end else if (bus.clear) begin
                    state_d    = IDLE;
                    clear_trip = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Distance, waiting-time and fare next-state logic.
    always_comb begin
        money_d   = money_q;
        dist_d    = dist_q;
        unit_d    = unit_q;
        presc_d   = presc_q;
        sec_d     = sec_q;
        dist_inc  = 1'b0;
        wait_inc  = 1'b0;
        money_sum = SUMW'(money_q);

        if (load_trip) begin
            money_d = MW'(BASE_FARE);
            dist_d  = '0;
            unit_d  = '0;
            presc_d = '0;
            sec_d   = '0;
        end else if (clear_trip) begin
            money_d = '0;
            dist_d  = '0;
            unit_d  = '0;
            presc_d = '0;
            sec_d   = '0;
        end else if (state_q == RUN) begin
            // unit_q counts metres since the last distance increment once past BASE_DIST.
            if (metre_strobe && (dist_q != DIST_MAX)) begin
                dist_d = dist_q + DW'(1);
                if (32'(dist_q) >= BASE_DIST) begin
                    if (unit_q == UW'(UNIT_DIST - 1)) begin
                        unit_d   = '0;
                        dist_inc = 1'b1;
                    end else begin
                        unit_d = unit_q + UW'(1);
                    end
                end
            end

            if (bus.wait_in) begin
                if (presc_q == PW'(CLK_HZ - 1)) begin
                    presc_d = '0;
                    if (sec_q == SW'(WAIT_UNIT - 1)) begin
                        sec_d    = '0;
                        wait_inc = 1'b1;
                    end else begin
                        sec_d = sec_q + SW'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end else begin
                presc_d = '0;
            end

            money_sum = SUMW'(money_q)
                      + (dist_inc ? SUMW'(UNIT_FARE) : SUMW'(0))
                      + (wait_inc ? SUMW'(WAIT_FARE) : SUMW'(0));
            money_d   = (money_sum > SUMW'(MONEY_MAX)) ? MW'(MONEY_MAX)
                                                       : money_sum[MW-1:0];
        end else begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            money_q <= '0;
            dist_q  <= '0;
            unit_q  <= '0;
            presc_q <= '0;
            sec_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            money_q <= money_d;
            dist_q  <= dist_d;
            unit_q  <= unit_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            busy_q  <= (state_d == RUN);
        end
    end

    assign bus.money  = money_q;
    assign bus.dist_m = dist_q;
    assign bus.busy   = busy_q;

endmodule
